// File: rtl/lsu_pkg.sv
// Shared encodings for the multi-cycle load/store unit: funct3 codes, FSM states,
// response error codes and the access-size decode.
package lsu_pkg;

  // RISC-V load/store funct3 width/sign codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RESP,
    DONE,
    ERR,
    TOUT
  } lsu_state_e;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_TOUT  = 2'b10;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_D
  } lsu_size_e;

  // funct3[1:0] encodes log2 of the access width; funct3[2] marks zero-extension
  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    return lsu_size_e'(f3[1:0]);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit: legality and alignment decode,
// store byte enables and lane replication, load field extraction and extension.
module lsu_align #(
  parameter int unsigned XLEN = 32
) (
  input  logic              store,
  input  logic [2:0]        funct3,
  input  logic [2:0]        addr_lo,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic              legal,
  output logic              misaligned,
  output logic [XLEN/8-1:0] be,
  output logic [XLEN-1:0]   wdata_rep,
  output logic [XLEN-1:0]   rdata_ext
);
  import lsu_pkg::*;

  localparam int unsigned NBYTES = XLEN / 8;
  localparam int unsigned OFFW   = $clog2(NBYTES);

  logic [OFFW-1:0]   off;
  lsu_size_e         size;
  int unsigned       nb;
  logic [NBYTES-1:0] mask;
  logic [XLEN-1:0]   shifted;
  logic              sign;

  assign off  = addr_lo[OFFW-1:0];
  assign size = f3_size(funct3);

  // Which funct3 codes exist for this direction and XLEN
  always_comb begin
    legal = 1'b0;
    if (store) begin
      case (funct3)
        F3_B, F3_H, F3_W: legal = 1'b1;
        F3_D:             legal = (XLEN == 64);
        default:          legal = 1'b0;
      endcase
    end else begin
      case (funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: legal = 1'b1;
        F3_D, F3_WU:                    legal = (XLEN == 64);
        default:                        legal = 1'b0;
      endcase
    end
  end

  // Natural alignment check plus access width in bytes and the unshifted lane mask
  always_comb begin
    misaligned = 1'b0;
    nb         = 1;
    mask       = NBYTES'(1);
    unique case (size)
      SZ_B: begin
        misaligned = 1'b0;
        nb         = 1;
        mask       = NBYTES'(1);
      end
      SZ_H: begin
        misaligned = addr_lo[0];
        nb         = 2;
        mask       = NBYTES'(3);
      end
      SZ_W: begin
        misaligned = |addr_lo[1:0];
        nb         = 4;
        mask       = NBYTES'(15);
      end
      SZ_D: begin
        misaligned = |addr_lo[2:0];
        nb         = 8;
        mask       = '1;
      end
    endcase
  end

  // Stores enable only the addressed lanes; loads always fetch the whole word
  always_comb begin
    be = store ? (mask << off) : '1;
  end

  // Replicate the low access-width field of the store data across every lane
  always_comb begin
    wdata_rep = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      wdata_rep[8*i +: 8] = wdata[8*(i % nb) +: 8];
    end
  end

  // Right-align the addressed field, then sign- or zero-extend above its width
  always_comb begin
    shifted = rdata >> {off, 3'b000};
    sign    = 1'b0;
    unique case (size)
      SZ_B: sign = shifted[7];
      SZ_H: sign = shifted[15];
      SZ_W: sign = shifted[31];
      SZ_D: sign = shifted[XLEN-1];
    endcase
    sign      = sign & ~funct3[2];
    rdata_ext = '0;
    for (int unsigned i = 0; i < XLEN; i++) begin
      rdata_ext[i] = (i < 8 * nb) ? shifted[i] : sign;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: accepts one op from the core, runs a granted
// request/response exchange with data memory, and returns a registered response
// pulse carrying extended load data or an alignment/timeout error.
module load_store_unit #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);
  import lsu_pkg::*;

  localparam int unsigned NBYTES = XLEN / 8;
  localparam int unsigned OFFW   = $clog2(NBYTES);
  localparam int unsigned CNTW   = $clog2(TIMEOUT);
  localparam logic [CNTW-1:0] TERM = CNTW'(TIMEOUT - 1);

  lsu_state_e        state_q;
  logic [CNTW-1:0]   cnt_q;
  logic              cap_store_q;
  logic [2:0]        cap_funct3_q;
  logic [2:0]        cap_addr_lo_q;

  logic              idle;
  logic [2:0]        al_funct3;
  logic [2:0]        al_addr_lo;
  logic              al_legal;
  logic              al_misaligned;
  logic [NBYTES-1:0] al_be;
  logic [XLEN-1:0]   al_wdata_rep;
  logic [XLEN-1:0]   al_rdata_ext;

  assign idle      = (state_q == IDLE);
  assign req_ready = idle;

  // The lane logic decodes the incoming request while idle and the captured one afterwards
  always_comb begin
    al_funct3  = idle ? req_funct3    : cap_funct3_q;
    al_addr_lo = idle ? req_addr[2:0] : cap_addr_lo_q;
  end

  lsu_align #(
    .XLEN(XLEN)
  ) u_align (
    .store     (req_store),
    .funct3    (al_funct3),
    .addr_lo   (al_addr_lo),
    .wdata     (req_wdata),
    .rdata     (mem_rdata),
    .legal     (al_legal),
    .misaligned(al_misaligned),
    .be        (al_be),
    .wdata_rep (al_wdata_rep),
    .rdata_ext (al_rdata_ext)
  );

  // FSM, timeout counter, request capture and all registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cap_store_q   <= 1'b0;
      cap_funct3_q  <= '0;
      cap_addr_lo_q <= '0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= ERR_OK;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_be        <= '0;
      mem_wdata     <= '0;
    end else begin
      // Response fields are a single-cycle pulse unless a terminal transition sets them
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= ERR_OK;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            cap_store_q   <= req_store;
            cap_funct3_q  <= req_funct3;
            cap_addr_lo_q <= req_addr[2:0];
            if (!al_legal || al_misaligned) begin
              state_q   <= ERR;
              rsp_valid <= 1'b1;
              rsp_err   <= ERR_ALIGN;
            end else begin
              state_q   <= REQ;
              cnt_q     <= '0;
              mem_req   <= 1'b1;
              mem_we    <= req_store;
              mem_addr  <= {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
              mem_be    <= al_be;
              mem_wdata <= al_wdata_rep;
            end
          end
        end
        REQ: begin
          // Terminal count beats a same-cycle grant; rvalid is meaningless before a grant
          if (cnt_q == TERM) begin
            state_q   <= TOUT;
            mem_req   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= ERR_TOUT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (mem_gnt) begin
              state_q <= RESP;
              mem_req <= 1'b0;
            end
          end
        end
        RESP: begin
          // A response arriving on the terminal count still completes the op
          if (mem_rvalid) begin
            state_q   <= DONE;
            rsp_valid <= 1'b1;
            rsp_rdata <= cap_store_q ? '0 : al_rdata_ext;
          end else if (cnt_q == TERM) begin
            state_q   <= TOUT;
            rsp_valid <= 1'b1;
            rsp_err   <= ERR_TOUT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE, ERR, TOUT: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit (XLEN=32, TIMEOUT=16): directed vector
// table, randomized ops against a behavioural model, and hand sequences for
// timeout, stray responses and mid-op reset.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  load_store_unit #(
    .XLEN   (XLEN),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_store (req_store),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          gd;   // REQ cycles before grant
    int          rv;   // RESP cycles before rvalid
    logic [31:0] er;
    logic [1:0]  ee;
    logic [31:0] ea;
    logic [3:0]  eb;
    logic [31:0] ew;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Observations of the latest op
  logic        o_valid, o_we, o_stable, o_after, o_ready_after;
  logic [31:0] o_rdata, o_addr, o_wdata;
  logic [1:0]  o_err;
  logic [3:0]  o_be;
  int          o_cycles, o_req_cycles;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, " rsp_valid"}, rsp_valid, 0);
    chk({tag, " rsp_rdata"}, rsp_rdata, 0);
    chk({tag, " rsp_err"},   rsp_err,   0);
    chk({tag, " mem_req"},   mem_req,   0);
    chk({tag, " mem_we"},    mem_we,    0);
    chk({tag, " mem_addr"},  mem_addr,  0);
    chk({tag, " mem_be"},    mem_be,    0);
    chk({tag, " mem_wdata"}, mem_wdata, 0);
    chk({tag, " req_ready"}, req_ready, 1);
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010, 3'b110: return 4;
      default:        return 8;
    endcase
  endfunction

  function automatic bit is_legal(input logic st, input logic [2:0] f3);
    if (st) return (f3 inside {3'b000, 3'b001, 3'b010}) || (XLEN == 64 && f3 == 3'b011);
    return (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
           (XLEN == 64 && f3 inside {3'b011, 3'b110});
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    longint unsigned bits, field, word;
    bits  = 8 * size_of(f3);
    word  = {32'h0, rd};
    field = (word >> (8 * (a % 4))) % (64'd1 << bits);
    if (!f3[2] && field >= (64'd1 << (bits - 1))) field = field + (64'h1_0000_0000 - (64'd1 << bits));
    return field[31:0];
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int m;
    m = ((1 << size_of(f3)) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    longint unsigned r;
    case (size_of(f3))
      1:       r = (wd % 256) * 64'h0101_0101;
      2:       r = (wd % 65536) * 64'h0001_0001;
      default: r = wd;
    endcase
    return r[31:0];
  endfunction

  // ---------------- op driver with memory responder ----------------
  task automatic op(input vec_t v);
    int   req_seen, resp_seen;
    logic granted;
    o_valid = 0; o_rdata = 0; o_err = 0; o_cycles = 0; o_req_cycles = 0;
    o_we = 0; o_addr = 0; o_be = 0; o_wdata = 0; o_stable = 1; o_after = 0; o_ready_after = 0;
    req_seen = 0; resp_seen = 0; granted = 0;
    req_valid  = 1'b1;
    req_store  = v.st;
    req_funct3 = v.f3;
    req_addr   = v.a;
    req_wdata  = v.wd;
    mem_rdata  = v.rd;
    @(posedge clk);
    #1;
    // Scramble request fields after accept so the op must run from captured state
    req_valid  = 1'b0;
    req_store  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (rsp_valid) begin
        o_valid  = 1;
        o_cycles = c;
        o_rdata  = rsp_rdata;
        o_err    = rsp_err;
        break;
      end
      if (mem_req) begin
        req_seen++;
        if (req_seen == 1) begin
          o_addr = mem_addr; o_be = mem_be; o_wdata = mem_wdata; o_we = mem_we;
        end else if (mem_addr !== o_addr || mem_be !== o_be || mem_wdata !== o_wdata ||
                     mem_we !== o_we) begin
          o_stable = 0;
        end
        if (req_seen > v.gd) begin
          mem_gnt = 1'b1;
          granted = 1;
        end
      end else if (granted) begin
        resp_seen++;
        if (resp_seen > v.rv) mem_rvalid = 1'b1;
      end
    end
    o_req_cycles = req_seen;
    @(negedge clk);
    mem_gnt       = 1'b0;
    mem_rvalid    = 1'b0;
    o_after       = rsp_valid;
    o_ready_after = req_ready;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int ec, erq;
    if (v.ee == ERR_ALIGN) begin
      ec = 1; erq = 0;
    end else if (v.ee == ERR_TOUT) begin
      ec = TIMEOUT + 1; erq = (v.gd + 1 < TIMEOUT) ? v.gd + 1 : TIMEOUT;
    end else begin
      ec = v.gd + v.rv + 3; erq = v.gd + 1;
    end
    op(v);
    chk($sformatf("%s rsp_seen", tag), o_valid, 1);
    chk($sformatf("%s rdata", tag), o_rdata, v.er);
    chk($sformatf("%s err", tag), o_err, v.ee);
    chk($sformatf("%s latency", tag), o_cycles, ec);
    chk($sformatf("%s req_cycles", tag), o_req_cycles, erq);
    if (v.ee != ERR_ALIGN) begin
      chk($sformatf("%s mem_addr", tag), o_addr, v.ea);
      chk($sformatf("%s mem_be", tag), o_be, v.eb);
      chk($sformatf("%s mem_we", tag), o_we, v.st);
      chk($sformatf("%s stable", tag), o_stable, 1);
      if (v.st) chk($sformatf("%s mem_wdata", tag), o_wdata, v.ew);
    end
    chk($sformatf("%s pulse", tag), o_after, 0);
    chk($sformatf("%s ready_after", tag), o_ready_after, 1);
  endtask

  vec_t vecs[17];

  initial begin
    vec_t v;
    int   seen;

    vecs[0]  = '{1'b0, F3_B,  32'h1003, 32'h0,      32'h80AABBCC, 0, 0,
                 32'hFFFFFF80, ERR_OK, 32'h1000, 4'hF, 32'h0};
    vecs[1]  = '{1'b0, F3_HU, 32'h1002, 32'h0,      32'h80AABBCC, 0, 0,
                 32'h000080AA, ERR_OK, 32'h1000, 4'hF, 32'h0};
    vecs[2]  = '{1'b0, F3_H,  32'h1002, 32'h0,      32'h80AABBCC, 0, 0,
                 32'hFFFF80AA, ERR_OK, 32'h1000, 4'hF, 32'h0};
    vecs[3]  = '{1'b0, F3_W,  32'h1000, 32'h0,      32'h12345678, 1, 2,
                 32'h12345678, ERR_OK, 32'h1000, 4'hF, 32'h0};
    vecs[4]  = '{1'b0, F3_BU, 32'h1001, 32'h0,      32'h80AABBCC, 0, 1,
                 32'h000000BB, ERR_OK, 32'h1000, 4'hF, 32'h0};
    vecs[5]  = '{1'b1, F3_B,  32'h2001, 32'h000000A5, 32'hFFFFFFFF, 2, 0,
                 32'h0, ERR_OK, 32'h2000, 4'b0010, 32'hA5A5A5A5};
    vecs[6]  = '{1'b1, F3_W,  32'h2004, 32'hDEADBEEF, 32'h13572468, 0, 0,
                 32'h0, ERR_OK, 32'h2004, 4'hF, 32'hDEADBEEF};
    vecs[7]  = '{1'b1, F3_H,  32'h1006, 32'h1234ABCD, 32'h55555555, 3, 0,
                 32'h0, ERR_OK, 32'h1004, 4'b1100, 32'hABCDABCD};
    vecs[8]  = '{1'b0, F3_W,  32'h1001, 32'h0, 32'h0, 0, 0, 32'h0, ERR_ALIGN, 32'h0, 4'h0, 32'h0};
    vecs[9]  = '{1'b1, F3_BU, 32'h1000, 32'h0, 32'h0, 0, 0, 32'h0, ERR_ALIGN, 32'h0, 4'h0, 32'h0};
    vecs[10] = '{1'b0, F3_H,  32'h1003, 32'h0, 32'h0, 0, 0, 32'h0, ERR_ALIGN, 32'h0, 4'h0, 32'h0};
    vecs[11] = '{1'b0, F3_D,  32'h0000, 32'h0, 32'h0, 0, 0, 32'h0, ERR_ALIGN, 32'h0, 4'h0, 32'h0};
    vecs[12] = '{1'b0, F3_WU, 32'h1000, 32'h0, 32'h0, 0, 0, 32'h0, ERR_ALIGN, 32'h0, 4'h0, 32'h0};
    vecs[13] = '{1'b0, F3_W,  32'h2000, 32'h0, 32'h0, 1000, 0,
                 32'h0, ERR_TOUT, 32'h2000, 4'hF, 32'h0};
    vecs[14] = '{1'b0, F3_W,  32'h2008, 32'h0, 32'hCAFEF00D, 0, 1000,
                 32'h0, ERR_TOUT, 32'h2008, 4'hF, 32'h0};
    vecs[15] = '{1'b0, F3_HU, 32'h200A, 32'h0, 32'hBEEF0000, 0, 14,
                 32'h0000BEEF, ERR_OK, 32'h2008, 4'hF, 32'h0};
    vecs[16] = '{1'b1, F3_D,  32'h3000, 32'h1, 32'h0, 0, 0, 32'h0, ERR_ALIGN, 32'h0, 4'h0, 32'h0};

    // Reset state
    #2;
    chk_zero_outputs("reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 17; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Stray rvalid after a timeout must not produce a response
    run_vec("tout", vecs[13]);
    seen = 0;
    mem_rvalid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (rsp_valid) seen++;
    end
    chk("stray_rvalid rsp", seen, 0);
    chk("stray_rvalid ready", req_ready, 1);

    // Randomized ops against the model
    for (int n = 0; n < 80; n++) begin
      int sz;
      v.st = 1'($urandom_range(0, 1));
      v.f3 = 3'($urandom_range(0, 7));
      v.a  = $urandom_range(0, 32'hFFFF);
      v.wd = $urandom;
      v.rd = $urandom;
      v.gd = $urandom_range(0, 3);
      v.rv = $urandom_range(0, 3);
      sz   = size_of(v.f3);
      if (!is_legal(v.st, v.f3) || (v.a % sz) != 0) begin
        v.ee = ERR_ALIGN; v.er = 0; v.ea = 0; v.eb = 0; v.ew = 0;
      end else begin
        v.ee = ERR_OK;
        v.ea = v.a - (v.a % 4);
        v.eb = v.st ? model_be(v.f3, v.a) : 4'hF;
        v.ew = v.st ? model_wdata(v.f3, v.wd) : 32'h0;
        v.er = v.st ? 32'h0 : model_load(v.f3, v.a, v.rd);
      end
      run_vec($sformatf("rand%0d", n), v);
    end

    // Reset pulled low while waiting for the response of a store
    req_valid  = 1'b1;
    req_store  = 1'b1;
    req_funct3 = F3_W;
    req_addr   = 32'h3004;
    req_wdata  = 32'h55AA55AA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("midreset pre mem_we", mem_we, 1);
    chk("midreset pre mem_be", mem_be, 4'hF);
    reset = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    mem_rvalid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (rsp_valid) seen++;
    end
    chk("midreset no rsp", seen, 0);
    chk("midreset ready", req_ready, 1);
    v = '{1'b0, F3_W, 32'h0, 32'h0, 32'hDEADBEEF, 0, 0,
          32'hDEADBEEF, ERR_OK, 32'h0, 4'hF, 32'h0};
    run_vec("post_reset", v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
